// File: rtl/stable_filter.sv
// rtl/stable_filter.sv - publishes din once it has been stable for STABLE_CYCLES rising edges
// Optional embedded checks are enabled with STABLE_FILTER_ASSERT_EN.
module stable_filter #(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             changed,
  output logic [7:0]       loss_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {SEEK, LOCK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             changed_q, changed_d;
  logic [7:0]       loss_cnt_q, loss_cnt_d;
  logic             stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEEK;
      din_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      changed_q    <= 1'b0;
      loss_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      changed_q    <= changed_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  always_comb begin
    stable       = (din == din_q);
    state_d      = state_q;
    din_d        = din;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    changed_d    = 1'b0;
    loss_cnt_d   = loss_cnt_q;
    case (state_q)
      SEEK: begin
        if (!stable) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = LOCK;
          dout_d       = din;
          dout_valid_d = 1'b1;
          cnt_d        = CNT_FULL;
          changed_d    = (din != dout_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOCK: begin
        // Any movement drops the lock, even a glitch back to the held value.
        if (!stable) begin
          state_d      = SEEK;
          cnt_d        = '0;
          dout_valid_d = 1'b0;
          if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = SEEK;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign changed    = changed_q;
  assign loss_cnt   = loss_cnt_q;

`ifdef STABLE_FILTER_ASSERT_EN
  a_dout_moves_only_with_changed: assert property (@(posedge clk) disable iff (!rst_n)
    !changed_q |-> $stable(dout_q))
    else $error("stable_filter: dout moved without changed");

  a_din_held_while_valid: assert property (@(posedge clk) disable iff (!rst_n)
    dout_valid_q && $past(dout_valid_q) |-> $stable(din_q))
    else $error("stable_filter: din_q moved while locked");

  a_changed_implies_valid: assert property (@(posedge clk) disable iff (!rst_n)
    changed_q |-> dout_valid_q)
    else $error("stable_filter: changed without dout_valid");
`else
`endif

endmodule

// File: tb/tb_stable_filter.sv
// tb/tb_stable_filter.sv - directed checks of stable_filter for WIDTH=1/N=3 and WIDTH=8/N=1
module tb_stable_filter;

  logic       clk;
  logic       rst_n;
  logic       din_a;
  logic       dout_a;
  logic       valid_a;
  logic       changed_a;
  logic [7:0] loss_a;
  logic [7:0] din_b;
  logic [7:0] dout_b;
  logic       valid_b;
  logic       changed_b;
  logic [7:0] loss_b;

  int vectors;
  int miscompares;

  stable_filter #(.WIDTH(1), .STABLE_CYCLES(3)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .dout(dout_a),
    .dout_valid(valid_a), .changed(changed_a), .loss_cnt(loss_a)
  );

  stable_filter #(.WIDTH(8), .STABLE_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .dout(dout_b),
    .dout_valid(valid_b), .changed(changed_b), .loss_cnt(loss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    din_a = 1'b0;
    din_b = 8'h00;
    #2;
    chk("rst_dout_a", dout_a, 0);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_changed_a", changed_a, 0);
    chk("rst_loss_a", loss_a, 0);
    chk("rst_dout_b", dout_b, 0);

    // release with din_a=1: edge 1 is not stable, lock at edge 4
    @(negedge clk);
    din_a = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("e1_valid_a", valid_a, 0);
    chk("e1_valid_b", valid_b, 1);
    chk("e1_changed_b", changed_b, 0);
    chk("e1_dout_b", dout_b, 8'h00);
    tick();
    chk("e2_valid_a", valid_a, 0);
    tick();
    chk("e3_valid_a", valid_a, 0);
    chk("e3_changed_a", changed_a, 0);
    tick();
    chk("e4_dout_a", dout_a, 1);
    chk("e4_valid_a", valid_a, 1);
    chk("e4_changed_a", changed_a, 1);
    tick();
    chk("e5_changed_a", changed_a, 0);
    chk("e5_valid_a", valid_a, 1);

    // one-cycle glitch back to the locked value
    @(negedge clk);
    din_a = 1'b0;
    tick();
    chk("g_valid_a", valid_a, 0);
    chk("g_loss_a", loss_a, 1);
    chk("g_dout_a", dout_a, 1);
    chk("g_changed_a", changed_a, 0);
    @(negedge clk);
    din_a = 1'b1;
    tick();
    chk("g7_valid_a", valid_a, 0);
    chk("g7_dout_a", dout_a, 1);
    tick();
    chk("g8_valid_a", valid_a, 0);
    tick();
    chk("g9_valid_a", valid_a, 0);
    chk("g9_dout_a", dout_a, 1);
    tick();
    chk("relock_valid_a", valid_a, 1);
    chk("relock_changed_a", changed_a, 0);
    chk("relock_dout_a", dout_a, 1);
    chk("relock_loss_a", loss_a, 1);

    // WIDTH=8, N=1: 0x00 -> 0xA5
    @(negedge clk);
    din_b = 8'hA5;
    tick();
    chk("b1_valid_b", valid_b, 0);
    chk("b1_loss_b", loss_b, 1);
    chk("b1_dout_b", dout_b, 8'h00);
    tick();
    chk("b2_dout_b", dout_b, 8'hA5);
    chk("b2_valid_b", valid_b, 1);
    chk("b2_changed_b", changed_b, 1);
    tick();
    chk("b3_changed_b", changed_b, 0);
    chk("b3_dout_b", dout_b, 8'hA5);

    // asynchronous reset pulse while locked
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dout_a", dout_a, 0);
    chk("ar_valid_a", valid_a, 0);
    chk("ar_changed_a", changed_a, 0);
    chk("ar_loss_a", loss_a, 0);
    chk("ar_dout_b", dout_b, 0);
    chk("ar_valid_b", valid_b, 0);
    chk("ar_loss_b", loss_b, 0);

    // toggle every negedge for 20 cycles: never locks
    @(negedge clk);
    din_a = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("tog%0d_valid_a", i), valid_a, 0);
      chk($sformatf("tog%0d_dout_a", i), dout_a, 0);
      @(negedge clk);
      din_a = ~din_a;
    end

    // hold to lock, then force 300 lock losses
    repeat (5) tick();
    chk("pre_sat_valid_a", valid_a, 1);
    chk("pre_sat_loss_a", loss_a, 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      din_a = ~din_a;
      repeat (4) @(posedge clk);
      if (i == 99) begin
        #1;
        chk("loss_100_a", loss_a, 100);
      end
    end
    #1;
    chk("sat_loss_a", loss_a, 255);
    chk("sat_valid_a", valid_a, 1);
    @(negedge clk);
    din_a = ~din_a;
    tick();
    chk("sat_hold_loss_a", loss_a, 255);
    chk("sat_hold_valid_a", valid_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
